uart_rx_cfg: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8N1 receiver. It supports configurable data width, parity, and one or two stop bits. Each bit is sampled three times and decided by majority vote. It reports parity, framing and break errors. It sits between the board RX pin and the byte-level command parser, and runs on the single system clock.

---
 rtl/uart_rx_cfg.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (5..9 data bits, none/even/odd parity,
// 1 or 2 stop bits) with 3-sample majority voting and parity / framing / break
// reporting. Sits between the board RX pin and the byte-level command parser.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   DATA_BITS     data bits per frame, 5..9, LSB first
//   PARITY        0 = none, 1 = even, 2 = odd
//   STOP_BITS     1 or 2
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   i_rx_s        asynchronous serial line, idles high
//   o_Rx_DV       one-cycle strobe: frame complete, outputs below valid
//   o_Rx_Data     received word, held until the next strobe
//   o_Parity_Err  parity mismatch on the last frame (held)
//   o_Frame_Err   a stop bit was sampled low on the last frame (held)
//   o_Break       all data bits, parity bit and first stop bit were 0 (held)
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_s,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break
);

  localparam int unsigned Mid  = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = 4;

  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] SmpA    = CntW'(Mid - 1);
  localparam logic [CntW-1:0] SmpB    = CntW'(Mid);
  localparam logic [CntW-1:0] SmpC    = CntW'(Mid + 1);
  localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);
  localparam logic            HasPar   = (PARITY != 0);
  localparam logic            OddPar   = (PARITY == 2);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StCleanup  = 3'd5,
    StWaitHigh = 3'd6
  } state_e;

  state_e state_q, state_d;

  logic                 rx_q1, rx_sync;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop0_q, stop0_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic                 rx_dv_q, rx_dv_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_q, break_d;

  logic                 cnt_last, at_dec, maj, in_bit, exp_par, first_stop_lo;
  logic [CntW-1:0]      cnt_inc;

  assign cnt_last = (cnt_q == CntLast);
  assign cnt_inc  = cnt_last ? '0 : cnt_q + 1'b1;
  assign at_dec   = (cnt_q == SmpC);
  // Third sample is the live rx_sync at MID+1; the first two were captured earlier.
  assign maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync) | (smp_q[1] & rx_sync);
  assign in_bit   = (state_q == StStart) || (state_q == StData) ||
                    (state_q == StParity) || (state_q == StStop);
  assign exp_par  = (^shift_q) ^ OddPar;
  // With one stop bit the first stop bit is the one being decided right now.
  assign first_stop_lo = (idx_q == '0) ? ~maj : ~stop0_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    smp_d       = smp_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    stop0_d     = stop0_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    rx_dv_d     = 1'b0;
    rx_data_d   = rx_data_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    break_d     = break_q;

    if (in_bit) begin
      cnt_d = cnt_inc;
      if (cnt_q == SmpA) smp_d[0] = rx_sync;
      if (cnt_q == SmpB) smp_d[1] = rx_sync;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_sync) begin
          state_d   = StStart;
          shift_d   = '0;
          par_bit_d = 1'b0;
          stop0_d   = 1'b0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end

      StStart: begin
        if (at_dec && maj) begin
          // Start bit did not hold low through the sample window: treat as glitch.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = StData;
        end
      end

      StData: begin
        // LSB-first shift from the top; after DATA_BITS shifts bit i sits at index i.
        if (at_dec) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (cnt_last) begin
          if (idx_q == LastData) begin
            idx_d   = '0;
            state_d = HasPar ? StParity : StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      StParity: begin
        if (at_dec) begin
          par_bit_d = maj;
          if (maj != exp_par) perr_d = 1'b1;
        end
        if (cnt_last) state_d = StStop;
      end

      StStop: begin
        if (at_dec && (idx_q == LastStop)) begin
          // Final stop bit: report now rather than waiting out the bit, so an
          // early start bit of the next frame is not missed.
          rx_dv_d     = 1'b1;
          rx_data_d   = shift_q;
          par_err_d   = perr_q;
          frame_err_d = ferr_q | ~maj;
          break_d     = (shift_q == '0) && (!HasPar || !par_bit_q) && first_stop_lo;
          state_d     = (ferr_q | ~maj) ? StWaitHigh : StCleanup;
          cnt_d       = '0;
          idx_d       = '0;
        end else begin
          if (at_dec) begin
            if (!maj) ferr_d = 1'b1;
            if (idx_q == '0) stop0_d = maj;
          end
          if (cnt_last) idx_d = idx_q + 1'b1;
        end
      end

      StCleanup: begin
        state_d = StIdle;
      end

      StWaitHigh: begin
        // A held-low line (break) must produce only one strobe.
        if (rx_sync) state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q1       <= 1'b1;
      rx_sync     <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      smp_q       <= '0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      stop0_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      rx_dv_q     <= 1'b0;
      rx_data_q   <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      rx_q1       <= i_rx_s;
      rx_sync     <= rx_q1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      smp_q       <= smp_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      stop0_q     <= stop0_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      rx_dv_q     <= rx_dv_d;
      rx_data_q   <= rx_data_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      break_q     <= break_d;
    end
  end

  assign o_Rx_DV      = rx_dv_q;
  assign o_Rx_Data    = rx_data_q;
  assign o_Parity_Err = par_err_q;
  assign o_Frame_Err  = frame_err_q;
  assign o_Break      = break_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four instances (8N1, 8E1, 8O1, 7N2) at 16 clocks per bit.
// Line levels are built per cycle into a queue, expected strobes are derived from
// the frame contents, and observed strobes are captured on the falling edge.
module tb_uart_rx_cfg;

  localparam int Cpb = 16;
  localparam int Mid = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1, rx3 = 1'b1;
  logic dv0, dv1, dv2, dv3;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic pe0, pe1, pe2, pe3;
  logic fe0, fe1, fe2, fe3;
  logic br0, br1, br2, br3;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .i_rx_s(rx0), .o_Rx_DV(dv0), .o_Rx_Data(d0),
    .o_Parity_Err(pe0), .o_Frame_Err(fe0), .o_Break(br0)
  );
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .i_rx_s(rx1), .o_Rx_DV(dv1), .o_Rx_Data(d1),
    .o_Parity_Err(pe1), .o_Frame_Err(fe1), .o_Break(br1)
  );
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .i_rx_s(rx2), .o_Rx_DV(dv2), .o_Rx_Data(d2),
    .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Break(br2)
  );
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .i_rx_s(rx3), .o_Rx_DV(dv3), .o_Rx_Data(d3),
    .o_Parity_Err(pe3), .o_Frame_Err(fe3), .o_Break(br3)
  );

  typedef struct {
    int ch;
    int cyc;
    int data;
    int pe;
    int fe;
    int br;
  } rec_t;

  rec_t mon_q[$];
  rec_t exp_q[$];
  logic lv_q[$];
  int   play_t0 = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic rec_t mk_rec(int ch, int c, int data, logic pe, logic fe, logic br);
    rec_t r;
    r.ch = ch; r.cyc = c; r.data = data; r.pe = int'(pe); r.fe = int'(fe); r.br = int'(br);
    return r;
  endfunction

  always @(negedge clk) begin
    if (dv0) mon_q.push_back(mk_rec(0, cyc, int'(d0), pe0, fe0, br0));
    if (dv1) mon_q.push_back(mk_rec(1, cyc, int'(d1), pe1, fe1, br1));
    if (dv2) mon_q.push_back(mk_rec(2, cyc, int'(d2), pe2, fe2, br2));
    if (dv3) mon_q.push_back(mk_rec(3, cyc, int'(d3), pe3, fe3, br3));
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int dbits_of(int ch);
    return (ch == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(int ch);
    return (ch == 1) ? 1 : (ch == 2) ? 2 : 0;
  endfunction
  function automatic int nstops_of(int ch);
    return (ch == 3) ? 2 : 1;
  endfunction
  function automatic int frame_bits(int ch);
    return 1 + dbits_of(ch) + ((par_of(ch) != 0) ? 1 : 0) + nstops_of(ch);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int ch, input logic v);
    case (ch)
      0: rx0 = v;
      1: rx1 = v;
      2: rx2 = v;
      default: rx3 = v;
    endcase
  endtask

  // Reference: what the receiver must report for a frame starting at line cycle off.
  // Strobe = 3 cycles to enter START, then (F-1) bit periods + MID + 2.
  task automatic push_exp(input int ch, input int off, input int data, input logic pbit,
                          input logic [1:0] stops);
    rec_t r;
    int   has_par;
    int   want_p;
    has_par = (par_of(ch) != 0) ? 1 : 0;
    want_p  = ($countones(data) % 2) ^ ((par_of(ch) == 2) ? 1 : 0);
    r.ch   = ch;
    r.cyc  = off + 3 + (frame_bits(ch) - 1) * Cpb + Mid + 2;
    r.data = data;
    r.pe   = (has_par == 1 && int'(pbit) != want_p) ? 1 : 0;
    r.fe   = (!stops[0] || (nstops_of(ch) == 2 && !stops[1])) ? 1 : 0;
    r.br   = (data == 0 && (has_par == 0 || !pbit) && !stops[0]) ? 1 : 0;
    exp_q.push_back(r);
  endtask

  task automatic push_level(input logic v, input int n);
    for (int i = 0; i < n; i++) lv_q.push_back(v);
  endtask

  // Frame-bit gbit gets a one-cycle inversion at cycle goff of that bit (gbit < 0: none).
  task automatic build_frame(input int ch, input int data, input logic pbit,
                             input logic [1:0] stops, input int last_len,
                             input int gbit, input int goff);
    logic bits[$];
    int   off;
    int   len;
    off = lv_q.size();
    bits.push_back(1'b0);
    for (int i = 0; i < dbits_of(ch); i++) bits.push_back(((data >> i) & 1) != 0);
    if (par_of(ch) != 0) bits.push_back(pbit);
    for (int i = 0; i < nstops_of(ch); i++) bits.push_back(stops[i]);
    for (int b = 0; b < bits.size(); b++) begin
      len = (b == bits.size() - 1) ? last_len : Cpb;
      for (int j = 0; j < len; j++) lv_q.push_back(bits[b] ^ (b == gbit && j == goff));
    end
    push_exp(ch, off, data, pbit, stops);
  endtask

  task automatic play(input int ch, input int ncyc);
    play_t0 = cyc;
    for (int i = 0; i < lv_q.size() && i < ncyc; i++) begin
      set_line(ch, lv_q[i]);
      tick(1);
    end
    lv_q.delete();
  endtask

  task automatic finish_seq(input string tag);
    check_eq({tag, " strobes"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      check_eq($sformatf("%s#%0d ch", tag, i), mon_q[i].ch, exp_q[i].ch);
      check_eq($sformatf("%s#%0d cycle", tag, i), mon_q[i].cyc, exp_q[i].cyc + play_t0);
      check_eq($sformatf("%s#%0d data", tag, i), mon_q[i].data, exp_q[i].data);
      check_eq($sformatf("%s#%0d perr", tag, i), mon_q[i].pe, exp_q[i].pe);
      check_eq($sformatf("%s#%0d ferr", tag, i), mon_q[i].fe, exp_q[i].fe);
      check_eq($sformatf("%s#%0d break", tag, i), mon_q[i].br, exp_q[i].br);
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int         data;
    logic       pbit;
    logic [1:0] stops;
    int         w;
    int         gbit;

    tick(3);
    check_eq("reset dv", int'(dv0), 0);
    check_eq("reset data", int'(d0), 0);
    check_eq("reset perr", int'(pe1), 0);
    check_eq("reset ferr", int'(fe3), 0);
    check_eq("reset break", int'(br0), 0);
    rst = 1'b0;
    tick(4);
    check_eq("idle dv", int'(dv0 | dv1 | dv2 | dv3), 0);

    // Randomized frames per configuration, with occasional bad parity, low stop
    // bits and single-cycle glitches inside a sample window (line cycles 7..9 of a bit).
    for (int ch = 0; ch < 4; ch++) begin
      for (int k = 0; k < 6; k++) begin
        data  = int'($urandom & ((32'd1 << dbits_of(ch)) - 1));
        pbit  = 1'($urandom_range(0, 1));
        stops = 2'b11;
        if ($urandom_range(0, 3) == 0) begin
          w = int'($urandom_range(0, nstops_of(ch) - 1));
          stops[w] = 1'b0;
        end
        gbit = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, frame_bits(ch) - 1)) : -1;
        build_frame(ch, data, pbit, stops, Cpb, gbit, int'($urandom_range(7, 9)));
        push_level(1'b1, int'($urandom_range(1, 3)) * Cpb);
      end
      play(ch, 32'h7fffffff);
      finish_seq($sformatf("rand_ch%0d", ch));
    end

    build_frame(0, 'hA5, 1'b0, 2'b11, Cpb, -1, 0);
    push_level(1'b1, 48);
    play(0, 32'h7fffffff);
    finish_seq("8n1_a5");

    build_frame(1, 'h3C, 1'b0, 2'b11, Cpb, -1, 0);
    push_level(1'b1, 32);
    build_frame(1, 'h3C, 1'b1, 2'b11, Cpb, -1, 0);
    push_level(1'b1, 32);
    play(1, 32'h7fffffff);
    finish_seq("8e1_3c");

    build_frame(2, 'h3C, 1'b1, 2'b11, Cpb, -1, 0);
    push_level(1'b1, 32);
    build_frame(2, 'h3C, 1'b0, 2'b11, Cpb, -1, 0);
    push_level(1'b1, 32);
    play(2, 32'h7fffffff);
    finish_seq("8o1_3c");

    push_level(1'b0, 3);
    push_level(1'b1, 220);
    play(0, 32'h7fffffff);
    finish_seq("start_glitch");

    // Line cycle 8 of a bit lines up with bit counter MID (2 sync flops + idle detect).
    build_frame(0, 'hFF, 1'b0, 2'b11, Cpb, 4, Mid + 1);
    push_level(1'b1, 32);
    play(0, 32'h7fffffff);
    finish_seq("data_glitch");

    // Second stop bit low, line stays low a while: one strobe only.
    build_frame(3, 'h55, 1'b0, 2'b01, Cpb, -1, 0);
    push_level(1'b0, 3 * Cpb);
    push_level(1'b1, 64);
    play(3, 32'h7fffffff);
    finish_seq("7n2_bad_stop");

    push_level(1'b0, 40 * Cpb);
    push_exp(0, 0, 0, 1'b0, 2'b00);
    push_level(1'b1, 48);
    build_frame(0, 'h81, 1'b0, 2'b11, Cpb, -1, 0);
    push_level(1'b1, 48);
    play(0, 32'h7fffffff);
    finish_seq("break");

    // Abort inside data bit 4; held outputs on every instance must clear.
    build_frame(0, 'h5A, 1'b0, 2'b11, Cpb, -1, 0);
    play(0, 5 * Cpb + 5);
    exp_q.delete();
    rst = 1'b1;
    rx0 = 1'b1;
    tick(1);
    check_eq("rst_mid dv", int'(dv0), 0);
    check_eq("rst_mid data", int'(d0), 0);
    check_eq("rst_mid perr ch1", int'(pe1), 0);
    check_eq("rst_mid data ch1", int'(d1), 0);
    check_eq("rst_mid ferr ch3", int'(fe3), 0);
    rst = 1'b0;
    push_level(1'b1, 240);
    play(0, 32'h7fffffff);
    finish_seq("rst_mid");

    // Stop bit cut to 11 cycles: the next start edge lands on the first IDLE cycle.
    build_frame(0, 'h12, 1'b0, 2'b11, 11, -1, 0);
    build_frame(0, 'h34, 1'b0, 2'b11, Cpb, -1, 0);
    push_level(1'b1, 48);
    play(0, 32'h7fffffff);
    finish_seq("b2b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
